// File: rtl/uart_pkg.sv
// Shared UART definitions: receive framer states and the frame/oversampling
// constants used by the framer, the phase counter and the baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input; every stage
// resets to 1 so an idle-high line sees no spurious edge after reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 receive framer: detects start bits on the synchronised line and samples
// each bit on the phase counter's centre tick, emitting bytes or framing errors.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 center_tick,
    output logic                 phase_arm,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic [2:0]           state_dbg
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    rx_state_e            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 rx_s;
    logic                 rx_d_q;
    logic                 fall_edge;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    assign fall_edge = rx_d_q & ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rx_d_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rx_d_q  <= rx_s;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            // A tick coinciding with the edge is deliberately ignored here.
            ST_IDLE: begin
                if (fall_edge) state_d = ST_START;
            end
            ST_START: begin
                if (center_tick) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (center_tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (center_tick) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            // Line must return high before another start bit can be seen.
            ST_BREAK: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign phase_arm  = (state_q == ST_IDLE) || (state_q == ST_BREAK);
    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer with a 16x phase-counter model driving
// center_tick and a scoreboard of expected bytes.
module tb_uart_rx_framer;

    localparam int BIT_CYC = 16;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       center_tick;
    logic       phase_arm;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic [2:0] state_dbg;

    logic       tick_inj;
    logic [3:0] ph_cnt;

    logic [7:0] exp_q[$];
    int n_checks;
    int n_pass;
    int vld_cnt, err_cnt, arm_low_cnt, busy_cnt;
    int overlap_cnt, width_viol;
    logic prev_vld, prev_err;

    uart_rx_framer #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .center_tick (center_tick),
        .phase_arm   (phase_arm),
        .data        (data),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // phase counter model: 16x oversample, centre tick at phase 7
    always @(posedge clk) begin
        if (rst || phase_arm) ph_cnt <= 4'd0;
        else                  ph_cnt <= ph_cnt + 4'd1;
    end
    assign center_tick = (!phase_arm && ph_cnt == 4'd7) || tick_inj;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (data_valid) begin
            logic have_exp;
            vld_cnt++;
            have_exp = (exp_q.size() != 0);
            check("valid_expected", {31'd0, have_exp}, 32'd1);
            if (have_exp) check("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
        if (frame_err) err_cnt++;
        if (data_valid && frame_err) overlap_cnt++;
        if ((data_valid && prev_vld) || (frame_err && prev_err)) width_viol++;
        if (!phase_arm) arm_low_cnt++;
        if (state_dbg != S_IDLE) busy_cnt++;
        prev_vld = data_valid;
        prev_err = frame_err;
    end

    // driver: bits[0]=start, bits[8:1]=data LSB first, bits[9]=stop
    task automatic drive_bits(input logic [9:0] bits, input int ncyc, input bit edge_tick);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            rx = bits[c / BIT_CYC];
            if (edge_tick && c == 2) tick_inj = 1'b1;
            if (edge_tick && c == 3) begin
                tick_inj = 1'b0;
                check("edge_wins_over_tick", {29'd0, state_dbg}, {29'd0, S_START});
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit edge_tick);
        drive_bits({stop, b, 1'b0}, 10 * BIT_CYC, edge_tick);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    initial begin
        int v0, e0, a0, b0;
        n_checks = 0; n_pass = 0;
        vld_cnt = 0; err_cnt = 0; arm_low_cnt = 0; busy_cnt = 0;
        overlap_cnt = 0; width_viol = 0;
        prev_vld = 1'b0; prev_err = 1'b0;
        rst = 1'b1; rx = 1'b1; tick_inj = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_phase_arm", {31'd0, phase_arm}, 32'd1);
        check("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);

        // idle line
        a0 = arm_low_cnt; v0 = vld_cnt; e0 = err_cnt;
        idle(100);
        check("idle_arm_low", arm_low_cnt - a0, 0);
        check("idle_valid", vld_cnt - v0, 0);
        check("idle_err", err_cnt - e0, 0);
        check("idle_data", {24'd0, data}, 32'd0);

        // back-to-back frames
        v0 = vld_cnt; e0 = err_cnt;
        exp_q.push_back(8'h55); exp_q.push_back(8'hA3);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        idle(20);
        check("b2b_valid_cnt", vld_cnt - v0, 2);
        check("b2b_err_cnt", err_cnt - e0, 0);
        check("b2b_data_hold", {24'd0, data}, 32'h0000_00A3);

        // glitch: low for 3 cycles only
        v0 = vld_cnt; e0 = err_cnt;
        @(negedge clk); rx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); rx = 1'b1;
        @(negedge clk);
        check("glitch_start", {29'd0, state_dbg}, {29'd0, S_START});
        check("glitch_arm_low", {31'd0, phase_arm}, 32'd0);
        idle(30);
        check("glitch_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});
        check("glitch_arm", {31'd0, phase_arm}, 32'd1);
        check("glitch_valid", vld_cnt - v0, 0);
        check("glitch_err", err_cnt - e0, 0);

        // break: stop bit low, line held low
        v0 = vld_cnt; e0 = err_cnt;
        send_frame(8'h00, 1'b0, 1'b0);
        check("break_err_cnt", err_cnt - e0, 1);
        check("break_state", {29'd0, state_dbg}, {29'd0, S_BREAK});
        check("break_data_kept", {24'd0, data}, 32'h0000_00A3);
        a0 = arm_low_cnt; e0 = err_cnt;
        for (int i = 0; i < 30 * BIT_CYC; i++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        check("break_quiet_arm", arm_low_cnt - a0, 0);
        check("break_quiet_err", err_cnt - e0, 0);
        check("break_quiet_valid", vld_cnt - v0, 0);
        idle(40);
        check("break_exit", {29'd0, state_dbg}, {29'd0, S_IDLE});
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(20);
        check("after_break_valid", vld_cnt - v0, 1);
        check("after_break_data", {24'd0, data}, 32'h0000_007E);

        // reset during bit 4 of 0xC3, line abandoned high
        v0 = vld_cnt; e0 = err_cnt;
        drive_bits({1'b1, 8'hC3, 1'b0}, 5 * BIT_CYC + 8, 1'b0);
        @(negedge clk); rst = 1'b1; rx = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        check("midrst_arm", {31'd0, phase_arm}, 32'd1);
        check("midrst_data", {24'd0, data}, 32'd0);
        idle(40);
        check("midrst_valid", vld_cnt - v0, 0);
        check("midrst_err", err_cnt - e0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);
        check("post_rst_data", {24'd0, data}, 32'h0000_003C);

        // random ticks in idle with line high
        v0 = vld_cnt; e0 = err_cnt; a0 = arm_low_cnt; b0 = busy_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rx = 1'b1;
            tick_inj = 1'($urandom_range(0, 1));
        end
        @(negedge clk); tick_inj = 1'b0;
        check("rand_tick_busy", busy_cnt - b0, 0);
        check("rand_tick_arm", arm_low_cnt - a0, 0);
        check("rand_tick_valid", vld_cnt - v0, 0);
        check("rand_tick_err", err_cnt - e0, 0);

        // tick coincident with falling edge
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 1'b1);
        idle(20);
        check("edge_tick_data", {24'd0, data}, 32'h0000_0096);

        check("exp_q_drained", exp_q.size(), 0);
        check("valid_err_overlap", overlap_cnt, 0);
        check("pulse_width", width_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Receive-side UART framer: synchronises the raw serial line, detects start bits, and assembles 8N1 frames into parallel bytes. It sits directly downstream of the oversampling phase counter. The framer drives that counter's `phase_arm` and consumes its `center_tick` to sample each bit at mid-period. Completed bytes are presented with a one-cycle valid pulse, and framing errors are flagged.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `SYNC_STAGES`, 2: flip-flop stages on `rx` before use (≥2).
- `clk` in 1: single system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial line, idle high.
- `center_tick` in 1: one-cycle pulse from phase counter at bit centre.
- `phase_arm` out 1: holds phase counter at phase 0 while high.
- `data` out DATA_BITS: last received byte.
- `data_valid` out 1: one-cycle pulse, `data` newly updated.
- `frame_err` out 1: one-cycle pulse, stop bit sampled low.

## Operation
- `rx` passes through SYNC_STAGES flops, giving `rx_s`, plus one history flop, `rx_d`. All of these reset to 1.
- Falling edge: `rx_d==1 && rx_s==0`.
- States:
  - IDLE: `phase_arm=1`. On falling edge → START. `center_tick` is ignored.
  - START: on `center_tick`, `rx_s==0` → DATA with bit index 0. `rx_s==1` → IDLE (glitch/false start, no output).
  - DATA: on `center_tick`, shift `rx_s` into shift register MSB, shifting right, so LSB-first arrives aligned. Increment index. After the DATA_BITS-th sample → STOP.
  - STOP: on `center_tick`, `rx_s==1` → load `data` from shift register, pulse `data_valid`, → IDLE. `rx_s==0` → pulse `frame_err`, leave `data` unchanged, → BREAK.
  - BREAK: `phase_arm=1`. Wait for `rx_s==1` → IDLE. A line held low never produces a new frame.
- `phase_arm` is a combinational decode: high in IDLE and BREAK, low otherwise.
- The bit index is `$clog2(DATA_BITS+1)` wide and cleared on entry to DATA. No wrap beyond DATA_BITS.
- Rules:
  - `data_valid` and `frame_err` are never high together.
  - `center_tick` and falling edge in the same IDLE cycle: the edge is taken and the tick is ignored.
- Reset values:
  - state IDLE, `phase_arm` 1
  - `data` 0, `data_valid` 0, `frame_err` 0
  - shift register 0, index 0
- Reset mid-frame: next cycle IDLE, no `data_valid`/`frame_err`, `data` cleared to 0.

## Timing
- `rx` edge → `rx_s`: SYNC_STAGES cycles. Falling edge detected the cycle `rx_s` first reads 0. State is START on the following cycle, and `phase_arm` falls that same cycle.
- All sampling uses `rx_s` in the cycle `center_tick` is high. The state/index update is visible next cycle.
- `data_valid` and `frame_err` are registered: high exactly one cycle, the cycle after the stop-bit `center_tick`. `data` is valid from that cycle and holds until the next `data_valid` or `rst`.
- IDLE is re-entered the same cycle `data_valid` rises. A new falling edge may be accepted from the next cycle, so back-to-back frames with one stop bit are supported.
- No backpressure; the consumer must capture `data` before the next `data_valid` (≥10 bit periods).

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK)
  - `UART_DATA_BITS`=8
  - `UART_OVERSAMPLE`=16, shared with the phase counter and baud generator
- One sub-module: `bit_synchronizer` (parameter STAGES, reset value 1), reused for other async inputs.
- The framer does not instantiate the phase counter; the top level wires `phase_arm`/`center_tick` between them.

## Test plan
- Reset, then idle line for 100 cycles → `phase_arm`=1 throughout; `data_valid`, `frame_err` never pulse; `data`=0.
- Frame 0x55, then frame 0xA3 back-to-back (one stop bit each), with phase counter at 16× oversample → two `data_valid` pulses, `data`=0x55 then 0xA3, one cycle each, `frame_err` never high.
- `rx` low for 3 `baud_en` periods, then high (glitch) → START sample reads 1, returns to IDLE, no `data_valid`, `phase_arm` reasserted.
- Frame 0x00 with stop bit low (break), line held low 30 bit periods, then idle, then frame 0x7E → one `frame_err` pulse, `data` unchanged; no activity during break; then `data_valid` with 0x7E.
- `rst` asserted one cycle during bit 4 of frame 0xC3 → IDLE next cycle, `phase_arm`=1, `data`=0, no pulse. The following frame 0x3C decodes correctly.
- `rx` and `center_tick` pulses randomly timed in IDLE with the line held high → no state change, no outputs.
